// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: default widths, NOP encoding,
// instruction field layout and the branch displacement sign extension.
package fetch_unit_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 16;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // Field positions: opcode [15:12], rdest [11:8], imm_hi [7:4], imm_lo [3:0]
    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] rdest;
        logic [3:0] imm_hi;
        logic [3:0] imm_lo;
    } instr_fields_t;

    function automatic logic [31:0] sext_disp(input logic [3:0] hi, input logic [3:0] lo);
        return {{24{hi[3]}}, hi, lo};
    endfunction

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection: hold, absolute jump, PC-relative branch or increment.
module pc_next_logic
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  pc_enabled,
    input  logic                  branch_mux,
    input  logic                  jump_mux,
    input  logic [3:0]            imm_high,
    input  logic [3:0]            imm_low,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    output logic [ADDR_WIDTH-1:0] pc_next
);

    always_comb begin
        pc_next = pc;
        if (pc_enabled) begin
            // Jump beats branch; branch base is the branch's own address.
            if (jump_mux)
                pc_next = jump_target;
            else if (branch_mux)
                pc_next = pc + ADDR_WIDTH'(sext_disp(imm_high, imm_low));
            else
                pc_next = pc + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// PC register, port-A address mux, instruction register with same-cycle
// bypass, JAL link value and retired-instruction counter.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pcEnabled,
    input  logic                  branchMux,
    input  logic                  jumpMux,
    input  logic [3:0]            immediateHigh,
    input  logic [3:0]            immediateLow,
    input  logic [ADDR_WIDTH-1:0] jumpTarget,
    input  logic                  pcOrRegMemMUX,
    input  logic [ADDR_WIDTH-1:0] regAddr,
    input  logic                  irLoad,
    input  logic [DATA_WIDTH-1:0] memData,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] memAddrA,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] linkValue,
    output logic [15:0]           retiredCount
);

    logic [ADDR_WIDTH-1:0] pc_d, pc_q;
    logic [DATA_WIDTH-1:0] ir_d, ir_q;
    logic [15:0]           retired_d, retired_q;

    pc_next_logic #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pc_next (
        .pc          (pc_q),
        .pc_enabled  (pcEnabled),
        .branch_mux  (branchMux),
        .jump_mux    (jumpMux),
        .imm_high    (immediateHigh),
        .imm_low     (immediateLow),
        .jump_target (jumpTarget),
        .pc_next     (pc_d)
    );

    always_comb begin
        ir_d      = irLoad ? memData : ir_q;
        retired_d = pcEnabled ? retired_q + 16'd1 : retired_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            ir_q      <= DATA_WIDTH'(NOP_INSTR);
            retired_q <= '0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    assign pc           = pc_q;
    assign memAddrA     = pcOrRegMemMUX ? regAddr : pc_q;
    assign instruction  = irLoad ? memData : ir_q;
    assign linkValue    = pc_q + ADDR_WIDTH'(1);
    assign retiredCount = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit with a queue-based scoreboard.
module tb_fetch_unit;

    localparam int SIG_PC   = 0;
    localparam int SIG_MA   = 1;
    localparam int SIG_INS  = 2;
    localparam int SIG_LINK = 3;
    localparam int SIG_RET  = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pcEnabled = 1'b0;
    logic        branchMux = 1'b0;
    logic        jumpMux = 1'b0;
    logic [3:0]  immediateHigh = '0;
    logic [3:0]  immediateLow = '0;
    logic [15:0] jumpTarget = '0;
    logic        pcOrRegMemMUX = 1'b0;
    logic [15:0] regAddr = '0;
    logic        irLoad = 1'b0;
    logic [15:0] memData = '0;
    logic [15:0] pc, memAddrA, instruction, linkValue, retiredCount;

    typedef struct {
        int          cyc;
        int          sig;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc_cnt = 0;
    int   total = 0;
    int   bad = 0;

    fetch_unit #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16),
        .RESET_PC   (16'h0000)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pcEnabled     (pcEnabled),
        .branchMux     (branchMux),
        .jumpMux       (jumpMux),
        .immediateHigh (immediateHigh),
        .immediateLow  (immediateLow),
        .jumpTarget    (jumpTarget),
        .pcOrRegMemMUX (pcOrRegMemMUX),
        .regAddr       (regAddr),
        .irLoad        (irLoad),
        .memData       (memData),
        .pc            (pc),
        .memAddrA      (memAddrA),
        .instruction   (instruction),
        .linkValue     (linkValue),
        .retiredCount  (retiredCount)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    // Monitor: compares every expectation tagged for the current cycle.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            exp_t        e;
            logic [15:0] act;
            e = sb.pop_front();
            case (e.sig)
                SIG_PC:   act = pc;
                SIG_MA:   act = memAddrA;
                SIG_INS:  act = instruction;
                SIG_LINK: act = linkValue;
                default:  act = retiredCount;
            endcase
            total++;
            if (e.cyc < cyc_cnt) begin
                bad++;
                $display("FAIL %s: stale expectation (cycle %0d checked at %0d)", e.name, e.cyc, cyc_cnt);
            end else if (act !== e.val) begin
                bad++;
                $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.val, e.cyc);
            end
        end
    end

    task automatic drive(input logic r, input logic pe, input logic br, input logic jm,
                         input logic [7:0] disp, input logic [15:0] jt, input logic mx,
                         input logic [15:0] ra, input logic il, input logic [15:0] md);
        @(posedge clock);
        #1;
        reset         = r;
        pcEnabled     = pe;
        branchMux     = br;
        jumpMux       = jm;
        immediateHigh = disp[7:4];
        immediateLow  = disp[3:0];
        jumpTarget    = jt;
        pcOrRegMemMUX = mx;
        regAddr       = ra;
        irLoad        = il;
        memData       = md;
    endtask

    task automatic expect_v(input int sig, input logic [15:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc_cnt;
        e.sig  = sig;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
    endtask

    task automatic incr();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
    endtask

    task automatic jump(input logic [15:0] tgt);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, tgt, 1'b0, 16'h0000, 1'b0, 16'h0000);
    endtask

    initial begin
        // Reset, then three increments
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        incr();
        expect_v(SIG_PC, 16'h0000, "reset_pc");
        expect_v(SIG_RET, 16'h0000, "reset_retired");
        expect_v(SIG_INS, 16'h0000, "reset_instr");
        expect_v(SIG_LINK, 16'h0001, "reset_link");
        expect_v(SIG_MA, 16'h0000, "reset_memaddr");
        incr();
        expect_v(SIG_PC, 16'h0001, "inc_pc1");
        incr();
        expect_v(SIG_PC, 16'h0002, "inc_pc2");
        jump(16'h0010);
        expect_v(SIG_PC, 16'h0003, "inc_pc3");
        expect_v(SIG_RET, 16'h0003, "retired_3");
        expect_v(SIG_LINK, 16'h0004, "link_at_3");

        // Branches from 0010
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'hFC, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        expect_v(SIG_PC, 16'h0010, "jump_to_0010");
        jump(16'h0010);
        expect_v(SIG_PC, 16'h000C, "branch_neg4");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h05, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        expect_v(SIG_PC, 16'h0010, "rejump_0010");
        jump(16'h0010);
        expect_v(SIG_PC, 16'h0015, "branch_pos5");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        expect_v(SIG_PC, 16'h0010, "rejump_0010b");
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000);
        expect_v(SIG_PC, 16'h0010, "branch_no_enable");
        jump(16'h0004);
        expect_v(SIG_PC, 16'h0010, "jump_no_enable");

        // Jump beats branch; link value before the edge
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000);
        expect_v(SIG_PC, 16'h0004, "pre_jal_pc");
        expect_v(SIG_LINK, 16'h0005, "jal_link");

        // IR capture with bypass, then hold while port A serves a data access
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hA5F0);
        expect_v(SIG_PC, 16'h1234, "jump_priority");
        expect_v(SIG_LINK, 16'h1235, "link_after_jal");
        expect_v(SIG_INS, 16'hA5F0, "ir_bypass");
        expect_v(SIG_MA, 16'h1234, "memaddr_pc");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h0040, 1'b0, 16'h1111);
        expect_v(SIG_INS, 16'hA5F0, "ir_hold");
        expect_v(SIG_MA, 16'h0040, "memaddr_reg");
        expect_v(SIG_RET, 16'h000A, "retired_10");

        // PC wrap at FFFF and negative branch across zero
        jump(16'hFFFF);
        incr();
        expect_v(SIG_PC, 16'hFFFF, "pc_ffff");
        expect_v(SIG_LINK, 16'h0000, "link_wrap");
        jump(16'h0002);
        expect_v(SIG_PC, 16'h0000, "pc_wrap");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h80, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        expect_v(SIG_PC, 16'h0002, "pc_0002");
        idle();
        expect_v(SIG_PC, 16'hFF82, "branch_neg128");
        expect_v(SIG_RET, 16'h000E, "retired_14");
        expect_v(SIG_INS, 16'hA5F0, "ir_still_held");

        // Reset overrides an in-flight jump and IR load
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 16'h1234, 1'b0, 16'h0000, 1'b1, 16'hBEEF);
        expect_v(SIG_INS, 16'hBEEF, "bypass_during_reset");
        idle();
        expect_v(SIG_PC, 16'h0000, "midop_reset_pc");
        expect_v(SIG_INS, 16'h0000, "midop_reset_ir");
        expect_v(SIG_RET, 16'h0000, "midop_reset_retired");
        expect_v(SIG_LINK, 16'h0001, "midop_reset_link");

        // Retired counter wrap
        for (int i = 0; i < 65535; i++) incr();
        idle();
        expect_v(SIG_RET, 16'hFFFF, "retired_ffff");
        expect_v(SIG_PC, 16'hFFFF, "pc_after_65535");
        incr();
        idle();
        expect_v(SIG_RET, 16'h0000, "retired_wrap");
        expect_v(SIG_PC, 16'h0000, "pc_inc_wrap");

        @(posedge clock);
        @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
